// File: rtl/battle_pkg.sv
// Shared types and helpers for the naval-battle turn controller.
// Board geometry, status codes, FSM states, cell index, popcount.
package battle_pkg;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = 6;

  localparam logic [1:0] ST_READY   = 2'b00;
  localparam logic [1:0] ST_HIT     = 2'b01;
  localparam logic [1:0] ST_MISS    = 2'b10;
  localparam logic [1:0] ST_INVALID = 2'b11;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_OVER
  } state_t;

  // Matrix bit 34 is line 1 / col 1; bit 0 is line 7 / col 5.
  function automatic logic [IDX_W-1:0] cell_idx(
    input logic [2:0] line,
    input logic [2:0] col
  );
    logic [IDX_W-1:0] l;
    logic [IDX_W-1:0] c;
    l = {3'd0, line} - 6'd1;
    c = {3'd0, col} - 6'd1;
    return 6'(CELLS - 1) - (l * 6'(COLS) + c);
  endfunction

  function automatic logic [IDX_W-1:0] popcount(
    input logic [CELLS-1:0] v
  );
    logic [IDX_W-1:0] n;
    n = '0;
    for (int i = 0; i < CELLS; i++)
      n = n + {5'd0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/battle_turn_controller_if.sv
// Board/datapath bundle of the turn controller.
// master = controller side, slave = buttons/matrix/display side.
interface battle_turn_controller_if;
  import battle_pkg::*;

  logic               button_confirmation;
  logic               button_clear;
  logic [5:0]         coord_at;
  logic [CELLS-1:0]   m_po;
  logic [CELLS-1:0]   m_at;
  logic               at_we;
  logic [IDX_W-1:0]   at_idx;
  logic               at_clr;
  logic [1:0]         status;
  logic [IDX_W-1:0]   shots;
  logic [IDX_W-1:0]   hits;
  logic               game_over;
  logic               busy;

  modport master (
    input  button_confirmation, button_clear,
    input  coord_at, m_po, m_at,
    output at_we, at_idx, at_clr, status,
    output shots, hits, game_over, busy
  );

  modport slave (
    output button_confirmation, button_clear,
    output coord_at, m_po, m_at,
    input  at_we, at_idx, at_clr, status,
    input  shots, hits, game_over, busy
  );

endinterface

// File: rtl/button_sync_edge.sv
// 2-FF synchronizer plus registered rising-edge pulse.
// Ports: clk, rst_n, btn (async raw), pulse (one cycle per press).
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      pulse <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      s3    <= s2;
      pulse <= s2 & ~s3;
    end
  end

endmodule

// File: rtl/battle_turn_controller.sv
// Turn sequencer: validates shots, writes attack matrix, scores.
// Ports: clk, clr (async active-low), bus (master side bundle).
module battle_turn_controller
  import battle_pkg::*;
(
  input logic clk,
  input logic clr,
  battle_turn_controller_if.master bus
);

  logic conf_p, clear_p;

  button_sync_edge u_conf (
    .clk   (clk),
    .rst_n (clr),
    .btn   (bus.button_confirmation),
    .pulse (conf_p)
  );

  button_sync_edge u_clear (
    .clk   (clk),
    .rst_n (clr),
    .btn   (bus.button_clear),
    .pulse (clear_p)
  );

  state_t           state, nxt;
  logic [5:0]       coord_q, coord_d;
  logic [IDX_W-1:0] total_q, total_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] shots_q, shots_d;
  logic [IDX_W-1:0] hits_q, hits_d;
  logic [1:0]       status_q, status_d;
  logic             we_q, we_d;
  logic             ac_q, ac_d;
  logic             go_q, go_d;
  logic             busy_q, busy_d;

  logic [2:0]       line, col;
  logic [IDX_W-1:0] idx, pop;
  logic             valid, fired, hit;

  assign line  = coord_q[5:3];
  assign col   = coord_q[2:0];
  assign valid = (line != 3'd0) && (col != 3'd0)
              && (col <= 3'd5);
  assign idx   = cell_idx(line, col);
  // Guarded so an out-of-board index never reaches m_at.
  assign fired = valid && bus.m_at[idx];
  assign hit   = bus.m_po[idx];
  assign pop   = popcount(bus.m_po);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_INIT;
      coord_q  <= '0;
      total_q  <= '0;
      idx_q    <= '0;
      shots_q  <= '0;
      hits_q   <= '0;
      status_q <= ST_READY;
      we_q     <= 1'b0;
      ac_q     <= 1'b0;
      go_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= nxt;
      coord_q  <= coord_d;
      total_q  <= total_d;
      idx_q    <= idx_d;
      shots_q  <= shots_d;
      hits_q   <= hits_d;
      status_q <= status_d;
      we_q     <= we_d;
      ac_q     <= ac_d;
      go_q     <= go_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    nxt = state;
    if (clear_p) begin
      nxt = S_INIT;
    end else begin
      unique case (state)
        S_INIT:  nxt = (pop == '0) ? S_OVER : S_IDLE;
        S_IDLE:  if (conf_p) nxt = S_CHECK;
        S_CHECK: nxt = (valid && !fired) ? S_WRITE : S_IDLE;
        // hits_q already includes this shot here.
        S_WRITE: nxt = (hits_q == total_q) ? S_OVER : S_IDLE;
        S_OVER:  nxt = S_OVER;
        default: nxt = S_INIT;
      endcase
    end
  end

  // Outputs are registered, so the write side effects are
  // computed while leaving CHECK and appear with at_we.
  always_comb begin
    coord_d  = coord_q;
    total_d  = total_q;
    idx_d    = idx_q;
    shots_d  = shots_q;
    hits_d   = hits_q;
    status_d = status_q;
    we_d     = (nxt == S_WRITE);
    ac_d     = (state == S_INIT);
    go_d     = (nxt == S_OVER);
    busy_d   = (nxt != S_IDLE) && (nxt != S_OVER);
    if (state == S_IDLE && nxt == S_CHECK)
      coord_d = bus.coord_at;
    if (state == S_INIT) begin
      total_d  = pop;
      shots_d  = '0;
      hits_d   = '0;
      status_d = ST_READY;
    end else if (we_d) begin
      idx_d    = idx;
      shots_d  = shots_q + 6'd1;
      hits_d   = hits_q + {5'd0, hit};
      status_d = hit ? ST_HIT : ST_MISS;
    end else if (state == S_CHECK && nxt == S_IDLE) begin
      status_d = ST_INVALID;
    end
  end

  assign bus.at_we     = we_q;
  assign bus.at_idx    = idx_q;
  assign bus.at_clr    = ac_q;
  assign bus.status    = status_q;
  assign bus.shots     = shots_q;
  assign bus.hits      = hits_q;
  assign bus.game_over = go_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_battle_turn_controller.sv
// Scoreboard bench for battle_turn_controller.
// Bench owns the attack matrix model and expected write queue.
module tb_battle_turn_controller;
  import battle_pkg::*;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  battle_turn_controller_if bus();

  battle_turn_controller dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    int idx;
    int st;
    int sh;
    int hi;
    int ov;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  int clr_cnt = 0;
  int b_we = 0;
  int b_total, b_shots, b_hits, b_status;
  int b_over;
  bit go_pend = 1'b0;
  int go_exp;

  logic [34:0] model_at = '0;
  assign bus.m_at = model_at;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (go_pend) begin
      check("game_over_next", 32'(bus.game_over), go_exp);
      go_pend = 1'b0;
    end
    if (bus.at_clr) begin
      clr_cnt++;
      model_at = '0;
    end
    if (bus.at_we) begin
      we_cnt++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("at_idx", 32'(bus.at_idx), e.idx);
        check("we_status", 32'(bus.status), e.st);
        check("we_shots", 32'(bus.shots), e.sh);
        check("we_hits", 32'(bus.hits), e.hi);
        check("go_at_we", 32'(bus.game_over), 0);
        go_pend = 1'b1;
        go_exp  = e.ov;
      end
      model_at[bus.at_idx] = 1'b1;
    end
  end

  task automatic settle_checks(input string tag);
    check({tag, "_we_cnt"}, we_cnt, b_we);
    check({tag, "_status"}, 32'(bus.status), b_status);
    check({tag, "_shots"}, 32'(bus.shots), b_shots);
    check({tag, "_hits"}, 32'(bus.hits), b_hits);
    check({tag, "_over"}, 32'(bus.game_over), b_over);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_sb"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input logic [34:0] po);
    int c0;
    clr = 1'b0;
    bus.m_po = po;
    bus.coord_at = '0;
    bus.button_confirmation = 1'b0;
    bus.button_clear = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    #1;
    check("rst_we", 32'(bus.at_we), 0);
    check("rst_clr", 32'(bus.at_clr), 0);
    check("rst_over", 32'(bus.game_over), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_cnt", {bus.at_idx, bus.shots, bus.hits}, 0);
    check("rst_status", 32'(bus.status), 0);
    c0 = clr_cnt;
    @(negedge clk);
    clr = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("at_clr_once", clr_cnt - c0, 1);
    b_total  = $countones(po);
    b_shots  = 0;
    b_hits   = 0;
    b_status = 0;
    b_over   = (b_total == 0) ? 1 : 0;
    settle_checks("init");
  endtask

  task automatic press(input logic [5:0] c, input int hold);
    int l, co, idx, hit;
    l  = int'(c[5:3]);
    co = int'(c[2:0]);
    idx = 34 - ((l - 1) * 5 + (co - 1));
    if (b_over == 0) begin
      if (l < 1 || l > 7 || co < 1 || co > 5 ||
          model_at[idx] == 1'b1) begin
        b_status = 3;
      end else begin
        hit = bus.m_po[idx] ? 1 : 0;
        b_shots++;
        b_hits += hit;
        b_status = hit ? 1 : 2;
        b_over = (b_hits == b_total) ? 1 : 0;
        b_we++;
        exp_q.push_back('{idx, b_status, b_shots,
                          b_hits, b_over});
      end
    end
    @(negedge clk);
    bus.coord_at = c;
    bus.button_confirmation = 1'b1;
    repeat (hold) @(negedge clk);
    bus.button_confirmation = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    settle_checks("press");
  endtask

  task automatic clear_and_fire(
    input logic [34:0] po,
    input logic [5:0]  c
  );
    int c0;
    c0 = clr_cnt;
    bus.m_po = po;
    @(negedge clk);
    bus.coord_at = c;
    bus.button_confirmation = 1'b1;
    bus.button_clear = 1'b1;
    repeat (4) @(negedge clk);
    bus.button_confirmation = 1'b0;
    bus.button_clear = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("clr_pulse", clr_cnt - c0, 1);
    b_total  = $countones(po);
    b_shots  = 0;
    b_hits   = 0;
    b_status = 0;
    b_over   = (b_total == 0) ? 1 : 0;
    settle_checks("clear");
  endtask

  initial begin
    // Empty fleet: game ends immediately, presses ignored.
    do_reset(35'd0);
    press(6'b011_010, 4);

    // Single ship at 23: one hit wins.
    do_reset(35'd1 << 23);
    press(6'b011_010, 4);
    press(6'b001_001, 4);

    // Ships at 34 and 0.
    do_reset((35'd1 << 34) | 35'd1);
    press(6'b001_010, 4);
    press(6'b001_110, 4);
    press(6'b000_001, 4);
    press(6'b001_010, 4);
    press(6'b001_001, 100);
    press(6'b111_101, 4);
    press(6'b011_011, 4);

    clear_and_fire((35'd1 << 34) | 35'd1, 6'b111_101);
    press(6'b111_101, 4);
    press(6'b111_000, 4);

    check("sb_final", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/battle_turn_controller.md
# battle_turn_controller

Turn sequencer for the 5×7 naval-battle datapath. It detects confirmation and clear button presses, validates the attack coordinate, and checks that coordinate against the ship preset matrix and the attack register matrix. It then issues a single write strobe into the attack matrix, updates the status code shown on the 7-segment display, and tracks shots, hits and end of game. It sits between the board buttons and coordinate switches and the attack-register/display datapath.

## Interface
- ROWS, 7, matrix lines
- COLS, 5, matrix columns
- CELLS, 35, ROWS×COLS; index width 6
- clk  in  1  system clock, rising edge
- clr  in  1  asynchronous active-low reset
- button_confirmation  in  1  raw active-high fire button, asynchronous to clk
- button_clear  in  1  raw active-high new-game button, asynchronous to clk
- coord_at  in  6  [5:3] line 1..7, [2:0] column 1..5
- m_po  in  35  ship preset matrix; 1 = ship cell
- m_at  in  35  current attack register contents; 1 = already fired
- at_we  out  1  one-cycle write strobe to attack matrix
- at_idx  out  6  cell index for at_we: 34 − ((line−1)·5 + (col−1))
- at_clr  out  1  one-cycle clear pulse to attack matrix
- status  out  2  00 ready, 01 hit, 10 miss, 11 invalid/repeat
- shots  out  6  accepted shots, 0..35
- hits  out  6  hits scored, 0..35
- game_over  out  1  all ship cells hit
- busy  out  1  high while the FSM is outside IDLE and OVER

## Operation
- Each button passes through a 2-FF synchronizer followed by a rising-edge register, which yields a one-cycle press pulse. A held button produces exactly one pulse.
- FSM states and behaviour:
  - INIT (one cycle): at_clr=1; clear shots, hits and status; latch total = popcount(m_po). If total==0, go to OVER, else go to IDLE.
  - IDLE: a press pulse latches coord_at into coord_q and moves to CHECK.
  - CHECK: valid = line∈1..7 and col∈1..5. Repeat = valid and m_at[idx].
    - If invalid or repeat: status=11, no write, no counter change, go to IDLE.
    - Otherwise go to WRITE.
  - WRITE: at_we=1 and at_idx=idx for one cycle; shots+1; hits+1 when m_po[idx]; status = m_po[idx] ? 01 : 10. Go to OVER if the new hits == total, else go to IDLE.
  - OVER: game_over=1; press pulses are ignored; status holds its last value.
- A clear press pulse in any state forces INIT on the next edge and has priority over a simultaneous confirmation pulse, which is dropped. A WRITE pending at that moment is not issued.
- A press arriving in CHECK or WRITE is dropped; presses are not queued.
- Counters cannot exceed 35 because repeats are rejected, so no saturation logic is needed.
- m_po is sampled only in INIT and CHECK/WRITE. Changes to m_po during play do not alter the latched total.

## Timing
- While clr=0: state INIT; at_we, at_clr, game_over and busy are 0; at_idx, shots and hits are 0; status=00. The first edge after clr releases executes INIT.
- All outputs are registered.
- Latency from the press pulse to at_we is 2 clk: IDLE→CHECK on the edge that samples the pulse, CHECK→WRITE on the next edge.
- status, shots and hits update on the same edge that raises at_we. game_over rises on the edge after WRITE.
- Latency from button edge to press pulse is 3 clk (2 sync + 1 edge register).
- at_idx is valid whenever at_we=1 and holds between writes.
- Asynchronous reset in any state, including WRITE, aborts the turn. No write is issued, and the controller re-enters INIT after reset release.

## Structure
- Package battle_pkg: ROWS, COLS, CELLS; status encodings ST_READY, ST_HIT, ST_MISS, ST_INVALID; FSM state enum; function cell_idx(line, col).
- One sub-module, button_sync_edge (2-FF synchronizer plus rising-edge pulse), instantiated once for each button.

## Test plan
- Reset with m_po=0: all outputs 0 while clr=0. After release, at_clr pulses for exactly 1 cycle, then game_over=1 and busy=0.
- m_po = only bit 23; press with coord_at=6'b011_010 (line 3, col 2): at_we pulses once with at_idx=23, status=01, shots=1, hits=1, and game_over=1 one cycle later.
- m_po bits 34 and 0; coord_at=6'b001_010 (line 1, col 2): at_idx=33, status=10, shots=1, hits=0, game_over=0.
- Invalid coord_at=6'b001_110 (col 6), then line 0 (6'b000_001): status=11 each time, no at_we, shots unchanged. Repeat fire on a cell with m_at[33]=1: status=11, no at_we.
- button_confirmation held high for 100 cycles gives exactly one at_we. Presses in OVER give no at_we and counters unchanged.
- Clear and confirmation pulses in the same cycle: at_clr pulses, shots=hits=0, status=00, and no at_we follows.
